// File: rtl/control_mac_filtro_pkg.sv
// Shared types for the FIR MAC sequencer: FSM state encoding and latency helper.
package control_mac_filtro_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ESCRIBE = 3'd1,
    MAC     = 3'd2,
    VACIA   = 3'd3,
    LISTO   = 3'd4
  } estado_t;

  // One cycle of RAM/ROM read latency plus the multiplier's internal stages.
  function automatic int lat_de(input int mul_lat);
    return 1 + mul_lat;
  endfunction

endpackage

// File: rtl/linea_retardo_valido.sv
// Delays the MAC issue flag by LAT cycles so en_acum lines up with the product.
module linea_retardo_valido #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic dato_i,
  output logic dato_o
);

  if (LAT == 0) begin : g_directo
    assign dato_o = dato_i;
  end else begin : g_tuberia
    logic [LAT-1:0] pipe_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= dato_i;
        for (int i = 1; i < LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dato_o = pipe_q[LAT-1];
  end

endmodule

// File: rtl/control_mac_filtro.sv
// Sequencer for the shared multiply-accumulate datapath of the FIR filter:
// writes each sample, issues TAPS MAC operations, drains the pipe and loads the result.
module control_mac_filtro
  import control_mac_filtro_pkg::*;
#(
  parameter int TAPS    = 5,
  parameter int ADDR_W  = 3,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              muestra_lista,
  output logic              we_muestra,
  output logic [ADDR_W-1:0] dir_escritura,
  output logic [ADDR_W-1:0] dir_muestra,
  output logic [ADDR_W-1:0] dir_coef,
  output logic              clr_acum,
  output logic              en_acum,
  output logic              carga_salida,
  output logic              ocupado,
  output logic              error_desborde
);

  localparam int                LAT       = lat_de(MUL_LAT);
  localparam int                CNT_W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0]  VACIA_FIN = CNT_W'(LAT - 1);
  localparam logic [ADDR_W-1:0] K_FIN     = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] TAPS_A    = ADDR_W'(TAPS);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] dir_muestra_q, dir_muestra_d;
  logic              we_q, clr_q, emite_q, carga_q, ocupado_q, error_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    estado_d      = estado_q;
    k_d           = k_q;
    wptr_d        = wptr_q;
    vcnt_d        = vcnt_q;
    dir_muestra_d = dir_muestra_q;
    unique case (estado_q)
      IDLE:    if (muestra_lista) estado_d = ESCRIBE;
      ESCRIBE: begin
        k_d      = '0;
        estado_d = MAC;
      end
      MAC: begin
        if (k_q == K_FIN) begin
          vcnt_d   = '0;
          estado_d = VACIA;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      VACIA: begin
        if (vcnt_q == VACIA_FIN) estado_d = LISTO;
        else                     vcnt_d   = vcnt_q + 1'b1;
      end
      LISTO: begin
        wptr_d   = (wptr_q == K_FIN) ? '0 : wptr_q + 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
    // Outputs are registered, so the read address is prepared for the state being entered.
    if (estado_d == MAC) begin
      dir_muestra_d = (wptr_q >= k_d) ? wptr_q - k_d : wptr_q + TAPS_A - k_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q      <= IDLE;
      k_q           <= '0;
      wptr_q        <= '0;
      vcnt_q        <= '0;
      dir_muestra_q <= '0;
      we_q          <= 1'b0;
      clr_q         <= 1'b0;
      emite_q       <= 1'b0;
      carga_q       <= 1'b0;
      ocupado_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      k_q           <= k_d;
      wptr_q        <= wptr_d;
      vcnt_q        <= vcnt_d;
      dir_muestra_q <= dir_muestra_d;
      we_q          <= (estado_d == ESCRIBE);
      clr_q         <= (estado_d == ESCRIBE);
      emite_q       <= (estado_d == MAC);
      carga_q       <= (estado_d == LISTO);
      ocupado_q     <= (estado_d != IDLE);
      error_q       <= error_q | (muestra_lista & ocupado_q);
    end
  end

  linea_retardo_valido #(
    .LAT (LAT)
  ) u_retardo (
    .clk    (clk),
    .reset  (reset),
    .dato_i (emite_q),
    .dato_o (en_acum)
  );

  assign we_muestra     = we_q;
  assign dir_escritura  = wptr_q;
  assign dir_muestra    = dir_muestra_q;
  assign dir_coef       = k_q;
  assign clr_acum       = clr_q;
  assign carga_salida   = carga_q;
  assign ocupado        = ocupado_q;
  assign error_desborde = error_q;

endmodule

// File: tb/tb_control_mac_filtro.sv
// Randomized bench: three sequencers (MUL_LAT 0, 1, 3) share stimulus and are compared
// every cycle against a timeline model derived from the strobe acceptance cycle.
module tb_control_mac_filtro;

  localparam int TAPS = 5;
  localparam int NDUT = 3;
  localparam int SEG  = 300;
  localparam int NSEG = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       muestra_lista = 1'b0;
  logic       we_v[NDUT], clr_v[NDUT], en_v[NDUT], carga_v[NDUT], ocup_v[NDUT], err_v[NDUT];
  logic [2:0] dire_v[NDUT], dirm_v[NDUT], dirc_v[NDUT];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    control_mac_filtro #(
      .TAPS    (TAPS),
      .ADDR_W  (3),
      .MUL_LAT ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .muestra_lista  (muestra_lista),
      .we_muestra     (we_v[g]),
      .dir_escritura  (dire_v[g]),
      .dir_muestra    (dirm_v[g]),
      .dir_coef       (dirc_v[g]),
      .clr_acum       (clr_v[g]),
      .en_acum        (en_v[g]),
      .carga_salida   (carga_v[g]),
      .ocupado        (ocup_v[g]),
      .error_desborde (err_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a sequence accepted in cycle t0 is described purely by d = cycle - t0.
  int lat_m[NDUT] = '{1, 2, 4};
  bit act_m[NDUT];
  int t0_m[NDUT];
  int wptr_m[NDUT];
  bit err_m[NDUT];
  bit valido = 1'b0;
  int resultados[NDUT];

  task automatic comparar(input int c);
    for (int j = 0; j < NDUT; j++) begin
      int  d, listo, k;
      bit  a;
      string p;
      a     = act_m[j];
      d     = c - t0_m[j];
      listo = 2 + TAPS + lat_m[j];
      p     = $sformatf("lat%0d c%0d", lat_m[j], c);
      check({p, " we_muestra"},     32'(we_v[j]),    32'(a && d == 1));
      check({p, " clr_acum"},       32'(clr_v[j]),   32'(a && d == 1));
      check({p, " en_acum"},        32'(en_v[j]),
            32'(a && d >= 2 + lat_m[j] && d <= 1 + TAPS + lat_m[j]));
      check({p, " carga_salida"},   32'(carga_v[j]), 32'(a && d == listo));
      check({p, " ocupado"},        32'(ocup_v[j]),  32'(a));
      check({p, " error_desborde"}, 32'(err_v[j]),   32'(err_m[j]));
      check({p, " dir_escritura"},  32'(dire_v[j]),  32'(wptr_m[j]));
      if (a && d >= 2 && d <= TAPS + 1) begin
        k = d - 2;
        check({p, " dir_coef"},    32'(dirc_v[j]), 32'(k));
        check({p, " dir_muestra"}, 32'(dirm_v[j]), 32'((wptr_m[j] - k + TAPS) % TAPS));
      end
    end
  endtask

  task automatic actualizar(input int c, input bit rst, input bit stb);
    for (int j = 0; j < NDUT; j++) begin
      if (rst) begin
        act_m[j]  = 1'b0;
        wptr_m[j] = 0;
        err_m[j]  = 1'b0;
      end else begin
        if (stb && act_m[j]) err_m[j] = 1'b1;
        if (act_m[j] && c == t0_m[j] + 2 + TAPS + lat_m[j]) begin
          act_m[j]  = 1'b0;
          wptr_m[j] = (wptr_m[j] + 1) % TAPS;
          resultados[j]++;
        end else if (stb && !act_m[j]) begin
          act_m[j] = 1'b1;
          t0_m[j]  = c;
        end
      end
    end
    if (rst) valido = 1'b1;
  endtask

  initial begin
    bit rst, stb, todos_libres;
    int modo;
    for (int j = 0; j < NDUT; j++) begin
      act_m[j] = 0; t0_m[j] = 0; wptr_m[j] = 0; err_m[j] = 0; resultados[j] = 0;
    end
    for (int c = 0; c < SEG * NSEG; c++) begin
      @(negedge clk);
      if (valido) comparar(c);
      // Mode 0: clean back-to-back traffic; 1: overlapping strobes; 2: clean with random resets.
      modo         = (c / SEG) % 3;
      todos_libres = !(act_m[0] || act_m[1] || act_m[2]);
      rst = (c % SEG == 0);
      stb = 1'b0;
      case (modo)
        0: stb = todos_libres && ($urandom_range(0, 1) == 1);
        1: stb = ($urandom_range(0, 5) == 0);
        default: begin
          stb = todos_libres && ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 39) == 0) rst = 1'b1;
        end
      endcase
      reset         = rst;
      muestra_lista = stb;
      actualizar(c, rst, stb);
    end
    @(negedge clk);
    if (resultados[0] < 8) check("resultados lat1 suficientes", 32'(resultados[0] >= 8), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
